lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store sequencer between execute stage and data-memory port. Takes base (rs1), offset
//  (operand-mux result) and rs2 store data; computes the effective address and runs one
//  req/gnt/rvalid transaction. Generates byte enables and shifted store data, returns the
//  sign/zero-extended load value, stalls the pipeline while busy, and raises precise exceptions.
// PARAMETERS
//  TIMEOUT  64  cycles in WAIT without mem_rvalid before an access fault; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous reset, active-high
//  req_valid   in   1   execute stage presents a memory op
//  req_ready   out  1   op accepted this cycle when req_valid&req_ready
//  req_store   in   1   1=store, 0=load
//  req_funct3  in   3   LB/SB=000 LH/SH=001 LW/SW=010 LBU=100 LHU=101
//  req_base    in   32  rs1
//  req_offset  in   32  offset from operand mux
//  req_wdata   in   32  rs2 (store data)
//  req_rd      in   5   load destination register
//  flush       in   1   kill in-flight op (branch/trap)
//  mem_req     out  1   memory request, held until mem_gnt
//  mem_we      out  1   write enable
//  mem_addr    out  32  word-aligned address {ea[31:2],2'b00}
//  mem_be      out  4   byte enables
//  mem_wdata   out  32  lane-shifted store data
//  mem_gnt     in   1   request accepted
//  mem_rvalid  in   1   response valid (earliest the cycle after mem_gnt)
//  mem_rdata   in   32  read word
//  mem_err     in   1   bus error, qualified by mem_rvalid
//  wb_valid    out  1   one-cycle load writeback pulse
//  wb_rd       out  5   writeback register
//  wb_data     out  32  extended load data
//  exc_valid   out  1   one-cycle exception pulse
//  exc_cause   out  4   2 illegal, 4 load misaligned, 5 load fault, 6 store misaligned, 7 store fault
//  stall       out  1   pipeline hold
// BEHAVIOUR
//  - Reset: state IDLE; mem_req, mem_we, wb_valid, exc_valid = 0; mem_addr, mem_be, mem_wdata,
//    wb_rd, wb_data, exc_cause = 0; timeout counter = 0.
//  - FSM IDLE -> REQ -> WAIT -> IDLE. req_ready = (state==IDLE). stall = (state!=IDLE) | (req_valid & ~req_ready).
//  - Accept in IDLE: ea = req_base + req_offset, mod 2^32, carry discarded. Register ea, funct3, store, rd, wdata.
//  - Checks, in priority order, at accept:
//    - Illegal funct3 (load 011/110/111; store >=011) -> cause 2.
//    - Misaligned (half & ea[0]; word & ea[1:0]!=0) -> cause 4 or 6.
//    - Either case: exc_valid pulses next cycle; state stays IDLE; no memory access.
//  - REQ: mem_req=1 with stable addr/we/be/wdata until mem_gnt. mem_gnt -> WAIT, mem_req drops the same edge.
//  - Byte enables: byte = 1<<ea[1:0]; half = 0011 or 1100 by ea[1]; word = 1111.
//    Store data is replicated into the enabled lanes.
//  - WAIT on mem_rvalid -> IDLE, and next cycle:
//    - mem_err -> exc_valid with cause 5 (load) or 7 (store).
//    - Else, load -> wb_valid with lane extracted by ea[1:0]; signed for 000/001, zero for 100/101.
//    - Else, store -> no pulse.
//  - Timeout counter runs in WAIT and clears on entry. Reaching TIMEOUT -> fault cause 5/7, return IDLE;
//    a late rvalid is ignored.
//  - Latency: accept cycle 0, mem_req cycle 1. gnt cycle 1 and rvalid cycle 2 -> wb_valid cycle 3
//    (3-cycle minimum). Back-to-back accept is allowed in the wb_valid cycle.
//  - flush:
//    - IDLE: also blocks acceptance that cycle.
//    - REQ before gnt: drop mem_req, go IDLE.
//    - REQ with gnt the same cycle, or WAIT: drain to rvalid/timeout, suppressing wb_valid and exc_valid.
//    - Also suppresses a pending exception pulse.
//  - wb_valid and exc_valid are never high together.
// STRUCTURE
//  - lsu_pkg: state_t enum {IDLE,REQ,WAIT}; funct3 localparams; exception-cause localparams.
//  - Sub-module lsu_align, combinational: ea[1:0] + funct3 -> mem_be/mem_wdata; rdata -> extended load data.
//  - lsu_ctrl holds FSM, registers, timeout counter and flush-drain flag.
// TESTING
//  - LW base=0x100 off=0x4: gnt cycle 1, rvalid cycle 2 rdata=0xDEADBEEF -> mem_addr=0x104, be=1111,
//    wb_valid cycle 3, wb_data=0xDEADBEEF.
//  - LB/LBU ea=0x103 rdata=0x80FF_FF7F -> be=1000; LB wb_data=0xFFFFFF80, LBU 0x00000080.
//  - SH ea=0x202 wdata=0x1234ABCD -> mem_be=1100, mem_wdata[31:16]=0xABCD, we=1, no wb_valid.
//  - LW ea=0x102 -> exc_valid cause 4 next cycle, mem_req never asserted. SW ea=0x101 -> cause 6.
//    funct3=011 -> cause 2.
//  - gnt withheld 5 cycles: mem_req/addr stable throughout, stall=1.
//    mem_rvalid with mem_err=1 on a store -> cause 7.
//  - flush in REQ pre-gnt -> mem_req drops, no pulses. flush in WAIT -> drain, no pulses, req_ready after rvalid.
//    rvalid withheld -> cause 5 after TIMEOUT=64 cycles.
//  - rst asserted mid-WAIT -> all outputs 0 immediately (async), state IDLE.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, funct3
// access-size codes, exception cause codes and small decode helpers used
// when an operation is accepted.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISAL = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISAL = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

  // Stores only have signed-size encodings; loads also have the unsigned ones.
  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    if (store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Only meaningful for legal funct3: f3[1:0] is 01 for halves, 10 for words.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] ea_lo);
    return ((f3[1:0] == 2'b01) && ea_lo[0]) ||
           ((f3[1:0] == 2'b10) && (ea_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bundle of the execute-stage request side and the data-memory port of the
// load/store unit.
//   slave  : the LSU view (consumes requests and memory responses)
//   master : the environment view (execute stage + memory model)
interface lsu_ctrl_if;
  // execute-stage side
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        flush;
  // data-memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  // writeback / exception / pipeline control
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic        stall;

  modport slave (
    input  req_valid, req_store, req_funct3, req_base, req_offset, req_wdata,
           req_rd, flush, mem_gnt, mem_rvalid, mem_rdata, mem_err,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           wb_valid, wb_rd, wb_data, exc_valid, exc_cause, stall
  );

  modport master (
    output req_valid, req_store, req_funct3, req_base, req_offset, req_wdata,
           req_rd, flush, mem_gnt, mem_rvalid, mem_rdata, mem_err,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           wb_valid, wb_rd, wb_data, exc_valid, exc_cause, stall
  );
endinterface

// File: rtl/lsu_ctrl_align.sv
// lsu_align: combinational lane steering for the LSU.
//   ea_lo_i   : low two bits of the effective address
//   funct3_i  : access size / signedness
//   wdata_i   : rs2 store data           -> wdata_o : replicated into every lane
//   be_o      : byte enables for the access
//   rdata_i   : memory read word         -> ld_data_o : selected lane, extended
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  ea_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [31:0] rdata_sh;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << ea_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = ea_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0; halves are aligned so ea_lo[0]=0.
  assign rdata_sh = rdata_i >> {ea_lo_i, 3'b000};

  always_comb begin
    case (funct3_i)
      F3_B:    ld_data_o = 32'($signed(rdata_sh[7:0]));
      F3_H:    ld_data_o = 32'($signed(rdata_sh[15:0]));
      F3_BU:   ld_data_o = {24'h0, rdata_sh[7:0]};
      F3_HU:   ld_data_o = {16'h0, rdata_sh[15:0]};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the execute stage and the data
// memory port. Accepts one op in IDLE, computes ea = base + offset, checks
// funct3 legality and alignment, runs a single req/gnt/rvalid transaction and
// returns an extended load value or a precise exception one cycle later.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : lsu_ctrl_if.slave -- request, memory port, writeback,
//              exception and stall signals
//   TIMEOUT  : WAIT cycles without mem_rvalid before an access fault
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  lsu_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [31:0]        ea_q, ea_d;
  logic [2:0]         f3_q, f3_d;
  logic               store_q, store_d;
  logic [4:0]         rd_q, rd_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               drain_q, drain_d;
  logic               wb_valid_q, wb_valid_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               exc_valid_q, exc_valid_d;
  logic [3:0]         exc_cause_q, exc_cause_d;

  logic [31:0]        ea_acc;
  logic [3:0]         be_w;
  logic [31:0]        wdata_w;
  logic [31:0]        ld_w;
  logic               timeout;
  logic               fault;

  assign ea_acc  = bus.req_base + bus.req_offset;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

  lsu_align u_align (
    .ea_lo_i   (ea_q[1:0]),
    .funct3_i  (f3_q),
    .wdata_i   (wdata_q),
    .rdata_i   (bus.mem_rdata),
    .be_o      (be_w),
    .wdata_o   (wdata_w),
    .ld_data_o (ld_w)
  );

  always_comb begin
    state_d     = state_q;
    ea_d        = ea_q;
    f3_d        = f3_q;
    store_d     = store_q;
    rd_d        = rd_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    exc_valid_d = 1'b0;
    exc_cause_d = exc_cause_q;
    // A late rvalid (after timeout) lands in fault-free IDLE and is ignored.
    fault       = bus.mem_rvalid ? bus.mem_err : 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          ea_d    = ea_acc;
          f3_d    = bus.req_funct3;
          store_d = bus.req_store;
          rd_d    = bus.req_rd;
          wdata_d = bus.req_wdata;
          drain_d = 1'b0;
          if (!f3_legal(bus.req_store, bus.req_funct3)) begin
            exc_valid_d = 1'b1;
            exc_cause_d = CAUSE_ILLEGAL;
          end else if (f3_misaligned(bus.req_funct3, ea_acc[1:0])) begin
            exc_valid_d = 1'b1;
            exc_cause_d = bus.req_store ? CAUSE_ST_MISAL : CAUSE_LD_MISAL;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // Once granted the access is committed; a flush only silences it.
        if (bus.mem_gnt) begin
          state_d = WAIT;
          cnt_d   = '0;
          drain_d = bus.flush;
        end else if (bus.flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d   = cnt_q + CNT_W'(1);
        drain_d = drain_q | bus.flush;
        if (bus.mem_rvalid || timeout) begin
          state_d = IDLE;
          if (!(drain_q || bus.flush)) begin
            if (fault) begin
              exc_valid_d = 1'b1;
              exc_cause_d = store_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
            end else if (!store_q) begin
              wb_valid_d = 1'b1;
              wb_rd_d    = rd_q;
              wb_data_d  = ld_w;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ea_q        <= '0;
      f3_q        <= '0;
      store_q     <= 1'b0;
      rd_q        <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
    end else begin
      state_q     <= state_d;
      ea_q        <= ea_d;
      f3_q        <= f3_d;
      store_q     <= store_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
    end
  end

  // Memory port is gated by REQ so it reads all-zero outside a request
  // and is held stable from registered fields while waiting for mem_gnt.
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = bus.mem_req & store_q;
  assign bus.mem_addr  = bus.mem_req ? {ea_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_be    = bus.mem_req ? be_w : 4'h0;
  assign bus.mem_wdata = bus.mem_we ? wdata_w : 32'h0;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.stall     = (state_q != IDLE) | (bus.req_valid & ~bus.req_ready);
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.exc_valid = exc_valid_q;
  assign bus.exc_cause = exc_cause_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;

  lsu_ctrl_if bus();

  lsu_ctrl #(.TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       nm;
    logic        store;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_exc;
    logic [3:0]  e_cause;
    logic [31:0] e_wb;
  } vec_t;

  vec_t v[16];

  function automatic vec_t mk(input string nm, input logic store, input logic [2:0] f3,
                              input logic [31:0] base, input logic [31:0] off,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic e_exc,
                              input logic [3:0] e_cause, input logic [31:0] e_wb);
    vec_t r;
    r.nm = nm; r.store = store; r.f3 = f3; r.base = base; r.off = off;
    r.wdata = wdata; r.rdata = rdata; r.e_addr = e_addr; r.e_be = e_be;
    r.e_wdata = e_wdata; r.e_exc = e_exc; r.e_cause = e_cause; r.e_wb = e_wb;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic store, input logic [2:0] f3,
                       input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] wdata);
    bus.req_store  = store;
    bus.req_funct3 = f3;
    bus.req_base   = base;
    bus.req_offset = off;
    bus.req_wdata  = wdata;
    bus.req_rd     = 5'd10;
    bus.req_valid  = 1'b1;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  task automatic run_vec(input vec_t t);
    issue(t.store, t.f3, t.base, t.off, t.wdata);
    if (t.e_exc) begin
      chk({t.nm, " exc_valid"}, 32'(bus.exc_valid), 32'd1);
      chk({t.nm, " exc_cause"}, 32'(bus.exc_cause), 32'(t.e_cause));
      chk({t.nm, " no mem_req"}, 32'(bus.mem_req), 32'd0);
      chk({t.nm, " ready"}, 32'(bus.req_ready), 32'd1);
      tick();
      chk({t.nm, " exc pulse end"}, 32'(bus.exc_valid), 32'd0);
      chk({t.nm, " still no mem_req"}, 32'(bus.mem_req), 32'd0);
    end else begin
      chk({t.nm, " mem_req"}, 32'(bus.mem_req), 32'd1);
      chk({t.nm, " mem_we"}, 32'(bus.mem_we), 32'(t.store));
      chk({t.nm, " mem_addr"}, bus.mem_addr, t.e_addr);
      chk({t.nm, " mem_be"}, 32'(bus.mem_be), 32'(t.e_be));
      chk({t.nm, " stall"}, 32'(bus.stall), 32'd1);
      if (t.store) chk({t.nm, " mem_wdata"}, bus.mem_wdata, t.e_wdata);
      bus.mem_gnt = 1'b1;
      tick();
      bus.mem_gnt = 1'b0;
      chk({t.nm, " mem_req drop"}, 32'(bus.mem_req), 32'd0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = t.rdata;
      bus.mem_err    = 1'b0;
      tick();
      bus.mem_rvalid = 1'b0;
      chk({t.nm, " wb_valid"}, 32'(bus.wb_valid), 32'(!t.store));
      if (!t.store) begin
        chk({t.nm, " wb_data"}, bus.wb_data, t.e_wb);
        chk({t.nm, " wb_rd"}, 32'(bus.wb_rd), 32'd10);
      end
      chk({t.nm, " no exc"}, 32'(bus.exc_valid), 32'd0);
      chk({t.nm, " ready"}, 32'(bus.req_ready), 32'd1);
      tick();
      chk({t.nm, " wb pulse end"}, 32'(bus.wb_valid), 32'd0);
    end
  endtask

  initial begin
    bus.req_valid = 0; bus.req_store = 0; bus.req_funct3 = 0; bus.req_base = 0;
    bus.req_offset = 0; bus.req_wdata = 0; bus.req_rd = 0; bus.flush = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.mem_err = 0;

    //           name            st f3      base          off           wdata         rdata         addr          be       wdata         exc cause wb
    v[0]  = mk("LW",             0, 3'b010, 32'h100, 32'h4,        32'h0,        32'hDEADBEEF, 32'h104, 4'b1111, 32'h0,        0, 4'd0, 32'hDEADBEEF);
    v[1]  = mk("LB 0x103",       0, 3'b000, 32'h100, 32'h3,        32'h0,        32'h80FFFF7F, 32'h100, 4'b1000, 32'h0,        0, 4'd0, 32'hFFFFFF80);
    v[2]  = mk("LBU 0x103",      0, 3'b100, 32'h100, 32'h3,        32'h0,        32'h80FFFF7F, 32'h100, 4'b1000, 32'h0,        0, 4'd0, 32'h00000080);
    v[3]  = mk("SH 0x202",       1, 3'b001, 32'h200, 32'h2,        32'h1234ABCD, 32'h0,        32'h200, 4'b1100, 32'hABCDABCD, 0, 4'd0, 32'h0);
    v[4]  = mk("LW mis",         0, 3'b010, 32'h100, 32'h2,        32'h0,        32'h0,        32'h0,   4'b0000, 32'h0,        1, 4'd4, 32'h0);
    v[5]  = mk("SW mis",         1, 3'b010, 32'h100, 32'h1,        32'h0,        32'h0,        32'h0,   4'b0000, 32'h0,        1, 4'd6, 32'h0);
    v[6]  = mk("ld f3 011",      0, 3'b011, 32'h100, 32'h0,        32'h0,        32'h0,        32'h0,   4'b0000, 32'h0,        1, 4'd2, 32'h0);
    v[7]  = mk("LH wrap",        0, 3'b001, 32'h10,  32'hFFFFFFF2, 32'h0,        32'h80011234, 32'h0,   4'b1100, 32'h0,        0, 4'd0, 32'hFFFF8001);
    v[8]  = mk("LHU hi",         0, 3'b101, 32'h10,  32'hFFFFFFF2, 32'h0,        32'h80011234, 32'h0,   4'b1100, 32'h0,        0, 4'd0, 32'h00008001);
    v[9]  = mk("SB 0x301",       1, 3'b000, 32'h300, 32'h1,        32'h000000A5, 32'h0,        32'h300, 4'b0010, 32'hA5A5A5A5, 0, 4'd0, 32'h0);
    v[10] = mk("st f3 100",      1, 3'b100, 32'h300, 32'h0,        32'h0,        32'h0,        32'h0,   4'b0000, 32'h0,        1, 4'd2, 32'h0);
    v[11] = mk("ld f3 111 prio", 0, 3'b111, 32'h100, 32'h3,        32'h0,        32'h0,        32'h0,   4'b0000, 32'h0,        1, 4'd2, 32'h0);
    v[12] = mk("LB lane0",       0, 3'b000, 32'h100, 32'h0,        32'h0,        32'h80FFFF7F, 32'h100, 4'b0001, 32'h0,        0, 4'd0, 32'h0000007F);
    v[13] = mk("SW 0x400",       1, 3'b010, 32'h400, 32'h0,        32'hCAFEF00D, 32'h0,        32'h400, 4'b1111, 32'hCAFEF00D, 0, 4'd0, 32'h0);
    v[14] = mk("LH mis",         0, 3'b001, 32'h100, 32'h1,        32'h0,        32'h0,        32'h0,   4'b0000, 32'h0,        1, 4'd4, 32'h0);
    v[15] = mk("LH lo",          0, 3'b001, 32'h100, 32'h0,        32'h0,        32'h80FFFF7F, 32'h100, 4'b0011, 32'h0,        0, 4'd0, 32'hFFFFFF7F);

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    chk("rst mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst exc_valid", 32'(bus.exc_valid), 32'd0);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) run_vec(v[i]);

    // gnt withheld 5 cycles, then store bus error
    issue(1'b1, 3'b010, 32'h500, 32'h0, 32'h55AA1234);
    for (int i = 0; i < 5; i++) begin
      chk("hold mem_req", 32'(bus.mem_req), 32'd1);
      chk("hold mem_addr", bus.mem_addr, 32'h500);
      chk("hold mem_wdata", bus.mem_wdata, 32'h55AA1234);
      chk("hold stall", 32'(bus.stall), 32'd1);
      tick();
    end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_err = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_err = 1'b0;
    chk("st err exc_valid", 32'(bus.exc_valid), 32'd1);
    chk("st err cause", 32'(bus.exc_cause), 32'd7);
    chk("st err no wb", 32'(bus.wb_valid), 32'd0);
    tick();

    // back-to-back accept in the wb_valid cycle
    issue(1'b0, 3'b010, 32'h100, 32'h8, 32'h0);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h11223344;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("b2b first wb", bus.wb_data, 32'h11223344);
    chk("b2b ready in wb cycle", 32'(bus.req_ready), 32'd1);
    issue(1'b0, 3'b100, 32'h100, 32'h1, 32'h0);
    chk("b2b second mem_req", 32'(bus.mem_req), 32'd1);
    chk("b2b second be", 32'(bus.mem_be), 32'b0010);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h0000AB00;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("b2b second wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("b2b second wb_data", bus.wb_data, 32'h000000AB);
    tick();

    // flush in IDLE blocks acceptance (misaligned op would otherwise trap)
    bus.flush = 1'b1;
    issue(1'b0, 3'b010, 32'h100, 32'h2, 32'h0);
    bus.flush = 1'b0;
    chk("idle flush no exc", 32'(bus.exc_valid), 32'd0);
    chk("idle flush no req", 32'(bus.mem_req), 32'd0);
    tick();

    // flush in REQ before gnt
    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'h0);
    chk("req flush pre mem_req", 32'(bus.mem_req), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("req flush mem_req drop", 32'(bus.mem_req), 32'd0);
    chk("req flush ready", 32'(bus.req_ready), 32'd1);
    chk("req flush stall", 32'(bus.stall), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("req flush no wb", 32'(bus.wb_valid), 32'd0);
      chk("req flush no exc", 32'(bus.exc_valid), 32'd0);
    end

    // flush in WAIT: drain to rvalid, no pulses
    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'h0);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("wait flush not ready", 32'(bus.req_ready), 32'd0);
    chk("wait flush stall", 32'(bus.stall), 32'd1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h12345678;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("wait flush ready", 32'(bus.req_ready), 32'd1);
    chk("wait flush no wb", 32'(bus.wb_valid), 32'd0);
    chk("wait flush no exc", 32'(bus.exc_valid), 32'd0);
    tick();
    chk("wait flush later no wb", 32'(bus.wb_valid), 32'd0);

    // rvalid withheld: load fault after 64 WAIT cycles, late rvalid ignored
    begin
      int cyc;
      bit seen;
      cyc = 0;
      seen = 1'b0;
      issue(1'b0, 3'b010, 32'h600, 32'h0, 32'h0);
      bus.mem_gnt = 1'b1;
      tick();
      bus.mem_gnt = 1'b0;
      for (int k = 1; k <= 80 && !seen; k++) begin
        tick();
        if (bus.exc_valid) begin
          seen = 1'b1;
          cyc = k;
        end
      end
      chk("timeout seen", 32'(seen), 32'd1);
      chk("timeout cycles", 32'(cyc), 32'd64);
      chk("timeout cause", 32'(bus.exc_cause), 32'd5);
      chk("timeout ready", 32'(bus.req_ready), 32'd1);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = 32'hFFFFFFFF;
      tick();
      bus.mem_rvalid = 1'b0;
      chk("late rvalid no wb", 32'(bus.wb_valid), 32'd0);
      chk("late rvalid no exc", 32'(bus.exc_valid), 32'd0);
    end

    // async reset in REQ
    issue(1'b1, 3'b010, 32'h700, 32'h0, 32'hFFFFFFFF);
    chk("pre rst mem_req", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async rst REQ mem_req", 32'(bus.mem_req), 32'd0);
    chk("async rst REQ mem_addr", bus.mem_addr, 32'd0);
    chk("async rst REQ mem_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;
    tick();

    // async reset in WAIT
    issue(1'b0, 3'b010, 32'h100, 32'h0, 32'h0);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    chk("pre rst wait stall", 32'(bus.stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async rst WAIT stall", 32'(bus.stall), 32'd0);
    chk("async rst WAIT ready", 32'(bus.req_ready), 32'd1);
    chk("async rst WAIT mem_req", 32'(bus.mem_req), 32'd0);
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hA5A5A5A5;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("post rst rvalid no wb", 32'(bus.wb_valid), 32'd0);
    chk("post rst rvalid no exc", 32'(bus.exc_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
